sequence_frame_tx: RTL and testbench

- Serial frame transmitter; the source side of the team's serial pattern-detect link (1-bit data plus data_valid).
- Accepts parallel payload words on a valid/ready handshake.
- Emits each word as one frame, MSB-first: fixed preamble, payload bits, one even-parity bit, then an idle gap with data_valid low.
- Feeds any downstream serial pattern detector directly.

---
 rtl/sequence_frame_tx.sv | 128 ++++++++++++
 tb/tb_sequence_frame_tx.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/sequence_frame_tx.sv
// Serial frame transmitter: parallel words in on valid/ready, frames out as
// preamble, payload MSB-first, even parity, then an idle gap with ser_valid low.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a word; in_ready=1
// PRE   | shifting out the preamble, MSB-first
// PAY   | shifting out the latched payload, MSB-first
// PAR   | even-parity bit on the line, frame_done pulses
// GAP   | ser_valid low for GAP cycles (never entered when GAP=0)
module sequence_frame_tx #(
  parameter int                DATA_W   = 8,
  parameter int                PRE_W    = 4,
  parameter logic [PRE_W-1:0]  PREAMBLE = 4'b0110,
  parameter int                GAP      = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              ser_data,
  output logic              ser_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam int MAXW = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int GW   = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_PAY  = 3'd2;
  localparam logic [2:0] S_PAR  = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] pay_sh;
  logic [PRE_W-1:0]  pre_sh;
  logic              parity;
  logic [CW-1:0]     bit_cnt;
  logic [GW-1:0]     gap_cnt;

  assign in_ready = (state == S_IDLE);
  assign busy     = ~in_ready;

  // The registered outputs always describe the bit of the current state, so each
  // transition loads the first bit of the next state; bit_cnt holds bits left after it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pay_sh     <= '0;
      pre_sh     <= '0;
      parity     <= 1'b0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      ser_data   <= 1'b0;
      ser_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (flush && (state != S_IDLE)) begin
        state     <= S_IDLE;
        ser_valid <= 1'b0;
        ser_data  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_valid) begin
              state     <= S_PRE;
              pay_sh    <= in_data;
              parity    <= ^in_data;
              pre_sh    <= PREAMBLE << 1;
              bit_cnt   <= CW'(PRE_W - 1);
              ser_valid <= 1'b1;
              ser_data  <= PREAMBLE[PRE_W-1];
            end
          end
          S_PRE: begin
            if (bit_cnt == '0) begin
              state    <= S_PAY;
              ser_data <= pay_sh[DATA_W-1];
              pay_sh   <= pay_sh << 1;
              bit_cnt  <= CW'(DATA_W - 1);
            end else begin
              ser_data <= pre_sh[PRE_W-1];
              pre_sh   <= pre_sh << 1;
              bit_cnt  <= bit_cnt - CW'(1);
            end
          end
          S_PAY: begin
            if (bit_cnt == '0) begin
              state      <= S_PAR;
              ser_data   <= parity;
              frame_done <= 1'b1;
            end else begin
              ser_data <= pay_sh[DATA_W-1];
              pay_sh   <= pay_sh << 1;
              bit_cnt  <= bit_cnt - CW'(1);
            end
          end
          S_PAR: begin
            ser_valid <= 1'b0;
            ser_data  <= 1'b0;
            if (GAP == 0) begin
              state <= S_IDLE;
            end else begin
              state   <= S_GAP;
              gap_cnt <= GW'(GAP - 1);
            end
          end
          S_GAP: begin
            if (gap_cnt == '0) state <= S_IDLE;
            else               gap_cnt <= gap_cnt - GW'(1);
          end
          default: begin
            state     <= S_IDLE;
            ser_valid <= 1'b0;
            ser_data  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_frame_tx.sv
// Bench for sequence_frame_tx: directed frames plus randomized traffic checked
// cycle by cycle against a bit-list model of the expected line activity.
module tb_sequence_frame_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] in_data;
  logic       in_valid, flush;
  logic       in_ready, ser_data, ser_valid, busy, frame_done;

  logic [3:0] in_data1;
  logic       in_valid1, flush1;
  logic       in_ready1, ser_data1, ser_valid1, busy1, frame_done1;

  always #5 clk = ~clk;

  sequence_frame_tx dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .ser_data(ser_data),
    .ser_valid(ser_valid), .busy(busy), .frame_done(frame_done)
  );

  sequence_frame_tx #(.DATA_W(4), .GAP(0)) dut_short (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .flush(flush1), .ser_data(ser_data1),
    .ser_valid(ser_valid1), .busy(busy1), .frame_done(frame_done1)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Model: each accepted word expands into the list of {valid, data, done}
  // line states it should produce; busy while that list is being played out.
  logic [2:0] exp_q[$];
  logic       m_busy = 1'b0;
  logic [2:0] m_out  = 3'b000;
  int         n_acc  = 0;
  int         dut_acc = 0;
  int         edge_n = 0;
  int         acc_last = 0;
  int         acc_prev = 0;

  task automatic model_edge();
    logic [3:0] pre;
    pre = 4'b0110;
    if (flush && m_busy) begin
      exp_q.delete();
      m_busy = 1'b0;
      m_out  = 3'b000;
    end else if (!m_busy && in_valid) begin
      for (int i = 3; i >= 0; i--) exp_q.push_back({1'b1, pre[i], 1'b0});
      for (int i = 7; i >= 0; i--) exp_q.push_back({1'b1, in_data[i], 1'b0});
      exp_q.push_back({1'b1, ^in_data, 1'b1});
      exp_q.push_back(3'b000);
      m_out  = exp_q.pop_front();
      m_busy = 1'b1;
      n_acc++;
    end else if (exp_q.size() > 0) begin
      m_out  = exp_q.pop_front();
      m_busy = 1'b1;
    end else begin
      m_out  = 3'b000;
      m_busy = 1'b0;
    end
  endtask

  task automatic step();
    logic pre_ready;
    pre_ready = in_ready;
    @(posedge clk);
    edge_n++;
    if (in_valid && pre_ready) begin
      dut_acc++;
      acc_prev = acc_last;
      acc_last = edge_n;
    end
    model_edge();
    #1;
    check("cyc", {ser_valid, ser_data, frame_done, in_ready, busy},
          {m_out, !m_busy, m_busy});
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", {ser_valid, ser_data, frame_done, in_ready, busy}, 5'b00010);
    exp_q.delete();
    m_busy = 1'b0;
    m_out  = 3'b000;
    #1 rst_n = 1'b1;
  endtask

  initial begin
    logic [12:0] got;
    logic [8:0]  seq07;
    logic [3:0]  pre_bits;
    logic [9:0]  pat;
    int          done_at;
    int          idx;

    in_data = '0; in_valid = 1'b0; flush = 1'b0;
    in_data1 = '0; in_valid1 = 1'b0; flush1 = 1'b0;
    #2;
    check("reset", {ser_valid, ser_data, frame_done, in_ready, busy}, 5'b00010);
    check("reset_short", {ser_valid1, ser_data1, frame_done1, in_ready1, busy1}, 5'b00010);
    #10 rst_n = 1'b1;

    // A5: full frame with explicit bit sequence
    in_data = 8'hA5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    got = '0; done_at = -1;
    for (int k = 1; k <= 15; k++) begin
      if (k <= 13) got = {got[11:0], ser_data};
      if (frame_done) done_at = k;
      if (k == 14) check("a5_gap_valid", ser_valid, 1'b0);
      if (k == 15) check("a5_ready", in_ready, 1'b1);
      if (k < 15) step();
    end
    check("a5_bits", got, 13'b0110_10100101_0);
    check("a5_done_at", done_at, 13);

    // 07 then FF with in_valid held: back-to-back period
    in_data = 8'h07; in_valid = 1'b1;
    step();
    in_data = 8'hFF;
    seq07 = '0;
    for (int k = 1; k <= 28; k++) begin
      if (k >= 5 && k <= 13) seq07 = {seq07[7:0], ser_data};
      if (k == 28) check("ff_parity", {ser_valid, ser_data, frame_done}, 3'b101);
      step();
    end
    in_valid = 1'b0;
    check("07_bits", seq07, 9'b00000111_1);
    check("b2b_period", acc_last - acc_prev, 15);
    repeat (3) step();

    // Reset in mid-payload, then a fresh frame
    in_data = $urandom; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    do_reset();
    repeat (4) step();
    in_data = 8'h3C; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    pre_bits = '0;
    for (int k = 1; k <= 4; k++) begin
      pre_bits = {pre_bits[2:0], ser_data};
      step();
    end
    check("post_rst_pre", pre_bits, 4'b0110);
    repeat (12) step();

    // flush at T+9, then flush together with accept in IDLE
    in_data = 8'hC3; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    flush = 1'b1;
    step();
    check("flush_out", {ser_valid, frame_done, in_ready}, 3'b001);
    in_data = 8'h5A; in_valid = 1'b1;
    step();
    check("flush_idle_acc", {busy, ser_valid, ser_data}, 3'b110);
    flush = 1'b0; in_valid = 1'b0;
    repeat (16) step();

    // GAP=0, DATA_W=4 instance with 9 held on its input
    pat = 10'b0110_1001_0_0;
    in_data1 = 4'h9; in_valid1 = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      idx = 9 - ((k - 1) % 10);
      check("short_stream", {ser_valid1, ser_data1, frame_done1},
            {(k % 10) != 0, pat[idx], (k % 10) == 9});
    end
    in_valid1 = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      in_valid = ($urandom % 10) < 6;
      in_data  = $urandom;
      flush    = ($urandom % 32) == 0;
      if (($urandom % 500) == 0) do_reset();
      else step();
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (16) step();
    check("accepts", dut_acc, n_acc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
